// File: rtl/dot_loader_pkg.sv
// Shared types and helpers for the dot-product vector loader.
// Holds the FSM state encoding, default vector geometry and counter sizing.
// No logic of its own; imported by the loader and its serializer.
package dot_loader_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int VECTOR_WIDTH_DEF = 4;
  localparam int VEC_BITS         = VECTOR_WIDTH_DEF * DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_START   = 2'd2,
    ST_WAIT_RD = 2'd3
  } state_t;

  // Counter width able to hold the value n itself (one spare bit over
  // $clog2), so a count that reaches a power of two never wraps.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/dot_vector_loader_serializer.sv
// Holds one A/B vector pair and presents it one element at a time, LSB element first.
// Latency: element 0 is on the outputs the cycle after i_load; each i_advance exposes the next.
// No backpressure of its own: the loader FSM decides when to load and advance.
module vector_serializer
  import dot_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_load,
  input  logic                               i_advance,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] i_vec_a,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] i_vec_b,
  output logic [DATA_WIDTH-1:0]              o_data_a,
  output logic [DATA_WIDTH-1:0]              o_data_b
);

  localparam int LP_BITS = VECTOR_WIDTH * DATA_WIDTH;

  logic [LP_BITS-1:0] r_sh_a;
  logic [LP_BITS-1:0] r_sh_b;

  // Parallel load, then shift right one element per advance; otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
    end else if (i_load) begin
      r_sh_a <= i_vec_a;
      r_sh_b <= i_vec_b;
    end else if (i_advance) begin
      r_sh_a <= r_sh_a >> DATA_WIDTH;
      r_sh_b <= r_sh_b >> DATA_WIDTH;
    end
  end

  // The current element is always the low slice, straight from the flops.
  assign o_data_a = r_sh_a[DATA_WIDTH-1:0];
  assign o_data_b = r_sh_b[DATA_WIDTH-1:0];

endmodule

// File: rtl/dot_vector_loader.sv
// Takes one packed A/B vector pair per handshake, writes it element by element, then kicks the reader.
// Latency: first write the cycle after the handshake; VECTOR_WIDTH writes, START pulse, then wait for done.
// Backpressure: in_ready is low from the handshake until reading_done (or timeout) returns the FSM to IDLE.
module dot_vector_loader
  import dot_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int VECTOR_WIDTH   = VECTOR_WIDTH_DEF,
  parameter int ADDR_WIDTH     = 5,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] i_in_a,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] i_in_b,
  output logic                               o_write_en,
  output logic [ADDR_WIDTH-1:0]              o_write_addr,
  output logic [DATA_WIDTH-1:0]              o_data_a,
  output logic [DATA_WIDTH-1:0]              o_data_b,
  output logic                               o_start_reading,
  input  logic                               i_reading_done,
  output logic                               o_busy,
  output logic [15:0]                        o_vectors_loaded,
  output logic                               o_timeout_err
);

  localparam int                    LP_IDX_W     = cnt_width(VECTOR_WIDTH);
  localparam int                    LP_TMO_W     = cnt_width(TIMEOUT_CYCLES + 1);
  localparam logic [LP_IDX_W-1:0]   LP_IDX_LAST  = LP_IDX_W'(VECTOR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [LP_TMO_W-1:0]   LP_TMO_LIMIT = LP_TMO_W'(TIMEOUT_CYCLES);
  localparam bit                    LP_TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LP_IDX_W-1:0]   r_idx;
  logic [LP_TMO_W-1:0]   r_tmo;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_vec_cnt;
  logic                  r_tmo_err;
  logic                  r_in_ready;
  logic                  r_write_en;
  logic                  r_start;
  logic                  r_busy;
  logic                  w_in_ready_nxt;
  logic                  w_write_en_nxt;
  logic                  w_start_nxt;
  logic                  w_busy_nxt;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_tmo_hit;

  assign w_accept = r_in_ready && i_in_valid;
  assign w_last   = (r_idx == LP_IDX_LAST);

  // r_tmo counts cycles elapsed since the START cycle (0 during START), so the
  // timeout flag lands exactly TIMEOUT_CYCLES cycles after START; a reading_done
  // in that same final cycle still wins.
  assign w_tmo_hit = LP_TMO_EN && (r_state == ST_WAIT_RD) && !i_reading_done &&
                     ((r_tmo + LP_TMO_W'(1)) >= LP_TMO_LIMIT);

  vector_serializer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .VECTOR_WIDTH (VECTOR_WIDTH)
  ) u_ser (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_accept),
    .i_advance ((r_state == ST_WRITE) && !w_last),
    .i_vec_a   (i_in_a),
    .i_vec_b   (i_in_b),
    .o_data_a  (o_data_a),
    .o_data_b  (o_data_b)
  );

  // State register, plus the state-decoded outputs registered alongside it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_write_en <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_write_en <= w_write_en_nxt;
      r_start    <= w_start_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state logic; reading_done only matters while waiting for the reader.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_WRITE;
      ST_WRITE:   if (w_last) w_state_nxt = ST_START;
      ST_START:   w_state_nxt = ST_WAIT_RD;
      ST_WAIT_RD: if (i_reading_done || w_tmo_hit) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs match it.
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_write_en_nxt = 1'b0;
    w_start_nxt    = 1'b0;
    w_busy_nxt     = 1'b1;
    case (w_state_nxt)
      ST_IDLE: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
      end
      ST_WRITE: w_write_en_nxt = 1'b1;
      ST_START: w_start_nxt    = 1'b1;
      default:  w_busy_nxt     = 1'b1;
    endcase
  end

  // Element index, write address, timeout counter and the completion/error status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx     <= '0;
      r_addr    <= '0;
      r_tmo     <= '0;
      r_vec_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_idx  <= '0;
            r_addr <= LP_BASE;
          end
        end
        ST_WRITE: begin
          if (w_last) begin
            r_tmo <= '0;
          end else begin
            r_idx  <= r_idx + LP_IDX_W'(1);
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        ST_START: r_tmo <= r_tmo + LP_TMO_W'(1);
        ST_WAIT_RD: begin
          if (i_reading_done) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
          end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
          end else if (LP_TMO_EN) begin
            r_tmo <= r_tmo + LP_TMO_W'(1);
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign o_in_ready       = r_in_ready;
  assign o_write_en       = r_write_en;
  assign o_write_addr     = r_addr;
  assign o_start_reading  = r_start;
  assign o_busy           = r_busy;
  assign o_vectors_loaded = r_vec_cnt;
  assign o_timeout_err    = r_tmo_err;

endmodule

// File: tb/tb_dot_vector_loader.sv
// Scoreboard bench for dot_vector_loader: expected element writes are queued at
// stimulus time and popped by a negedge monitor whenever write_en is seen.
// Two instances: base address 0 with a 10-cycle timeout, and base address 16.
module tb_dot_vector_loader;
  import dot_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic [VEC_BITS-1:0] in_a = '0;
  logic [VEC_BITS-1:0] in_b = '0;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic rd_auto = 1'b0, rd_stale = 1'b0, rd1 = 1'b0;

  logic        o_in_ready0, o_write_en0, o_start0, o_busy0, o_err0;
  logic [4:0]  o_addr0;
  logic [7:0]  o_a0, o_b0;
  logic [15:0] o_vl0;
  logic        o_in_ready1, o_write_en1, o_start1, o_busy1, o_err1;
  logic [4:0]  o_addr1;
  logic [7:0]  o_a1, o_b1;
  logic [15:0] o_vl1;

  dot_vector_loader #(.DATA_WIDTH(8), .VECTOR_WIDTH(4), .ADDR_WIDTH(5),
                      .BASE_ADDR(0), .TIMEOUT_CYCLES(10)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid0), .o_in_ready(o_in_ready0),
    .i_in_a(in_a), .i_in_b(in_b), .o_write_en(o_write_en0), .o_write_addr(o_addr0),
    .o_data_a(o_a0), .o_data_b(o_b0), .o_start_reading(o_start0),
    .i_reading_done(rd_auto | rd_stale), .o_busy(o_busy0),
    .o_vectors_loaded(o_vl0), .o_timeout_err(o_err0));

  dot_vector_loader #(.DATA_WIDTH(8), .VECTOR_WIDTH(4), .ADDR_WIDTH(5),
                      .BASE_ADDR(16), .TIMEOUT_CYCLES(255)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid1), .o_in_ready(o_in_ready1),
    .i_in_a(in_a), .i_in_b(in_b), .o_write_en(o_write_en1), .o_write_addr(o_addr1),
    .o_data_a(o_a1), .o_data_b(o_b1), .o_start_reading(o_start1),
    .i_reading_done(rd1), .o_busy(o_busy1),
    .o_vectors_loaded(o_vl1), .o_timeout_err(o_err1));

  // Expected write entry: {3'b0, addr, a, b} -> hex reads as addr_a_b.
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  int st_cyc0[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, st0 = 0, st1 = 0;
  int rd_delay = -1;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference packing: element i of a/b is bits [i*8 +: 8], address base+i.
  task automatic push_exp(input int sel, input logic [VEC_BITS-1:0] a,
                          input logic [VEC_BITS-1:0] b, input int n);
    logic [4:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = 5'((sel == 0 ? 0 : 16) + i);
      if (sel == 0) q0.push_back({3'b0, ad, a[i*8 +: 8], b[i*8 +: 8]});
      else          q1.push_back({3'b0, ad, a[i*8 +: 8], b[i*8 +: 8]});
    end
  endtask

  task automatic send(input int sel, input logic [VEC_BITS-1:0] a,
                      input logic [VEC_BITS-1:0] b, input bit keep);
    int n;
    in_a = a;
    in_b = b;
    if (sel == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
    n = 0;
    while (((sel == 0) ? !o_in_ready0 : !o_in_ready1) && n < 100) begin
      tick;
      n++;
    end
    chk("handshake_ready", (sel == 0) ? o_in_ready0 : o_in_ready1, 1);
    tick;
    if (!keep) begin
      if (sel == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
    end
  endtask

  task automatic wait_vl(input logic [15:0] target);
    int n;
    n = 0;
    while (o_vl0 !== target && n < 200) begin
      tick;
      n++;
    end
    chk("vectors_loaded", o_vl0, target);
  endtask

  task automatic wait_start0;
    int n;
    n = 0;
    while (!o_start0 && n < 50) begin
      tick;
      n++;
    end
    chk("start_seen", o_start0, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, o_in_ready0, 1);
    chk({tag, "_write_en"}, o_write_en0, 0);
    chk({tag, "_start"}, o_start0, 0);
    chk({tag, "_busy"}, o_busy0, 0);
    chk({tag, "_timeout_err"}, o_err0, 0);
    chk({tag, "_addr"}, o_addr0, 0);
    chk({tag, "_data_a"}, o_a0, 0);
    chk({tag, "_data_b"}, o_b0, 0);
    chk({tag, "_vl"}, o_vl0, 0);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en) begin
      if (o_write_en0) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr0_unexpected: got %0h expected no write", {3'b0, o_addr0, o_a0, o_b0});
        end else begin
          chk("wr0", {8'b0, 3'b0, o_addr0, o_a0, o_b0}, {8'b0, q0.pop_front()});
        end
      end
      if (o_write_en1) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr1_unexpected: got %0h expected no write", {3'b0, o_addr1, o_a1, o_b1});
        end else begin
          chk("wr1", {8'b0, 3'b0, o_addr1, o_a1, o_b1}, {8'b0, q1.pop_front()});
        end
      end
      if (o_start0) begin
        st0++;
        st_cyc0.push_back(cyc);
      end
      if (o_start1) st1++;
    end
  end

  // Automatic reader for DUT0: answers each start pulse after rd_delay cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_start0 && rd_delay >= 0) begin
        repeat (rd_delay) begin
          @(posedge clk);
          #1;
        end
        rd_auto = 1'b1;
        @(posedge clk);
        #1;
        rd_auto = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VEC_BITS-1:0] va[3];
    logic [VEC_BITS-1:0] vb[3];
    int base_st, first;

    va[0] = 32'hA3A2A1A0; vb[0] = 32'h0F0E0D0C;
    va[1] = 32'hB3B2B1B0; vb[1] = 32'h1B1A1918;
    va[2] = 32'hC3C2C1C0; vb[2] = 32'h2726_2524;

    // Reset state
    repeat (3) tick;
    check_reset("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    tick;

    // Single vector, reader answers 3 cycles after start
    rd_delay = 3;
    q0.push_back(24'h000105); q0.push_back(24'h010206);
    q0.push_back(24'h020307); q0.push_back(24'h030408);
    send(0, 32'h04030201, 32'h08070605, 1'b0);
    wait_vl(16'd1);
    chk("single_in_ready", o_in_ready0, 1);
    chk("single_busy", o_busy0, 0);
    chk("single_starts", st0, 1);
    chk("single_q_empty", q0.size(), 0);

    // Back-to-back, in_valid held high, reader answers 1 cycle after start
    rd_delay = 1;
    base_st = st0;
    st_cyc0.delete();
    for (int k = 0; k < 3; k++) begin
      push_exp(0, va[k], vb[k], 4);
      send(0, va[k], vb[k], 1'b1);
    end
    in_valid0 = 1'b0;
    wait_vl(16'd4);
    chk("b2b_starts", st0 - base_st, 3);
    chk("b2b_start_count", st_cyc0.size(), 3);
    if (st_cyc0.size() == 3) begin
      chk("b2b_period_1", st_cyc0[1] - st_cyc0[0], 7);
      chk("b2b_period_2", st_cyc0[2] - st_cyc0[1], 7);
    end
    chk("b2b_q_empty", q0.size(), 0);

    // Stale reading_done during WRITE must be ignored
    rd_delay = -1;
    push_exp(0, 32'h44332211, 32'h88776655, 4);
    send(0, 32'h44332211, 32'h88776655, 1'b0);
    tick;
    rd_stale = 1'b1;
    tick;
    rd_stale = 1'b0;
    wait_start0;
    tick;
    tick;
    chk("stale_vl_held", o_vl0, 4);
    chk("stale_busy", o_busy0, 1);
    rd_stale = 1'b1;
    tick;
    rd_stale = 1'b0;
    chk("stale_vl_done", o_vl0, 5);
    chk("stale_idle", o_busy0, 0);

    // Timeout: no reading_done at all
    push_exp(0, 32'h0D0C0B0A, 32'h0605_0403, 4);
    send(0, 32'h0D0C0B0A, 32'h06050403, 1'b0);
    wait_start0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (o_err0 && first < 0) first = k;
    end
    chk("timeout_latency", first, 10);
    chk("timeout_vl", o_vl0, 5);
    chk("timeout_busy", o_busy0, 0);
    chk("timeout_in_ready", o_in_ready0, 1);
    rd_delay = 1;
    push_exp(0, 32'h5A5B5C5D, 32'hE1E2E3E4, 4);
    send(0, 32'h5A5B5C5D, 32'hE1E2E3E4, 1'b0);
    wait_vl(16'd6);
    chk("timeout_sticky", o_err0, 1);

    // Reset during the second write cycle
    rd_delay = -1;
    push_exp(0, 32'h77665544, 32'h3322_1100, 2);
    send(0, 32'h77665544, 32'h33221100, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    check_reset("midrst");
    rst = 1'b0;
    base_st = st0;
    repeat (10) tick;
    chk("midrst_no_start", st0, base_st);
    chk("midrst_q_empty", q0.size(), 0);

    // BASE_ADDR = 16 instance
    q1.push_back(24'h100105); q1.push_back(24'h110206);
    q1.push_back(24'h120307); q1.push_back(24'h130408);
    send(1, 32'h04030201, 32'h08070605, 1'b0);
    first = 0;
    while (!o_start1 && first < 50) begin
      tick;
      first++;
    end
    chk("base16_start", o_start1, 1);
    tick;
    rd1 = 1'b1;
    tick;
    rd1 = 1'b0;
    chk("base16_vl", o_vl1, 1);
    chk("base16_busy", o_busy1, 0);
    chk("base16_err", o_err1, 0);
    chk("base16_starts", st1, 1);
    chk("base16_q_empty", q1.size(), 0);

    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
